// File: rtl/taillight_seq.sv
// Turn-signal / hazard taillight sequencer.
// A free-running step counter paces the animation; the FSM and all lamp
// registers change only on step ticks.
// Optional feature: define TAILLIGHT_CHASE_EN to let `mode` select chase
// frames; without it only fill frames exist and `mode` is ignored.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | no activity, lamps dark, requests evaluated on every tick
// S_LEFT   | left pass running, pos walks 0..LAMPS (LAMPS = all-off frame)
// S_RIGHT  | right pass running, same as S_LEFT on the right side
// S_HAZARD | both sides blink all-on / all-off each tick
module taillight_seq #(
    parameter int LAMPS       = 3,
    parameter int STEP_CYCLES = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             left_req,
    input  logic             right_req,
    input  logic             hazard,
    input  logic             mode,
    output logic [LAMPS-1:0] left_lamps,
    output logic [LAMPS-1:0] right_lamps,
    output logic             busy
);

    localparam int CW = $clog2(STEP_CYCLES);
    localparam int PW = $clog2(LAMPS + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(STEP_CYCLES - 1);
    localparam logic [PW-1:0]    POS_OFF  = PW'(LAMPS);
    localparam logic [LAMPS-1:0] ALL_ON   = '1;

    typedef enum logic [1:0] {S_IDLE, S_LEFT, S_RIGHT, S_HAZARD} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    pos_q, pos_d;
    logic [LAMPS-1:0] left_q, left_d;
    logic [LAMPS-1:0] right_q, right_d;
    logic             tick;
    logic             chase;
    logic             start_eval;

`ifdef TAILLIGHT_CHASE_EN
    assign chase = mode;
`else
    // Tie chase off so the chase decode folds away; keep mode visibly consumed.
    logic unused_mode;
    assign unused_mode = mode;
    assign chase       = 1'b0;
`endif

    // Lamp pattern for a given position; pos == LAMPS is always dark.
    function automatic logic [LAMPS-1:0] frame(input logic [PW-1:0] p, input logic ch);
        logic [LAMPS-1:0] f;
        for (int i = 0; i < LAMPS; i++) begin
            f[i] = ch ? (PW'(i) == p) : (PW'(i) <= p);
        end
        if (p == POS_OFF) begin
            f = '0;
        end
        return f;
    endfunction

    assign tick  = (cnt_q == CNT_LAST);
    assign cnt_d = tick ? '0 : cnt_q + CW'(1);

    // Step counter, state and lamp registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
            pos_q   <= '0;
            left_q  <= '0;
            right_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            pos_q   <= pos_d;
            left_q  <= left_d;
            right_q <= right_d;
        end
    end

    // Next state, position and frame; everything holds between ticks.
    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        left_d     = left_q;
        right_d    = right_q;
        start_eval = 1'b0;
        if (tick) begin
            unique case (state_q)
                S_IDLE: start_eval = 1'b1;
                S_LEFT, S_RIGHT: begin
                    if (hazard) begin
                        state_d = S_HAZARD;
                        pos_d   = '0;
                        left_d  = ALL_ON;
                        right_d = ALL_ON;
                    end else if (pos_q == POS_OFF) begin
                        // End of pass: behave like IDLE so a held request loops seamlessly.
                        start_eval = 1'b1;
                    end else begin
                        pos_d = pos_q + PW'(1);
                        if (state_q == S_LEFT) begin
                            left_d = frame(pos_q + PW'(1), chase);
                        end else begin
                            right_d = frame(pos_q + PW'(1), chase);
                        end
                    end
                end
                S_HAZARD: begin
                    if (left_q == ALL_ON) begin
                        left_d  = '0;
                        right_d = '0;
                        if (!hazard) begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        left_d  = ALL_ON;
                        right_d = ALL_ON;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (start_eval) begin
                state_d = S_IDLE;
                pos_d   = '0;
                left_d  = '0;
                right_d = '0;
                if (hazard || (left_req && right_req)) begin
                    state_d = S_HAZARD;
                    left_d  = ALL_ON;
                    right_d = ALL_ON;
                end else if (left_req) begin
                    state_d = S_LEFT;
                    left_d  = frame('0, chase);
                end else if (right_req) begin
                    state_d = S_RIGHT;
                    right_d = frame('0, chase);
                end
            end
        end
    end

    assign left_lamps  = left_q;
    assign right_lamps = right_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_taillight_seq.sv
// Bench for taillight_seq with LAMPS = 3, STEP_CYCLES = 4.
// A behavioural model is checked against the DUT on every cycle; directed
// scenarios add literal expectations, followed by randomized stimulus.
module tb_taillight_seq;

    localparam int LAMPS = 3;
    localparam int STEP  = 4;
`ifdef TAILLIGHT_CHASE_EN
    localparam bit CHASE = 1'b1;
`else
    localparam bit CHASE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic left_req = 1'b0;
    logic right_req = 1'b0;
    logic hazard = 1'b0;
    logic mode = 1'b0;
    logic [LAMPS-1:0] left_lamps;
    logic [LAMPS-1:0] right_lamps;
    logic busy;

    taillight_seq #(.LAMPS(LAMPS), .STEP_CYCLES(STEP)) dut (
        .clk(clk), .rst(rst), .left_req(left_req), .right_req(right_req),
        .hazard(hazard), .mode(mode), .left_lamps(left_lamps),
        .right_lamps(right_lamps), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: m_side 0 = idle, 1 = left, 2 = right, 3 = hazard.
    int m_cnt = 0;
    int m_side = 0;
    int m_pos = 0;
    logic [LAMPS-1:0] m_l = '0;
    logic [LAMPS-1:0] m_r = '0;
    bit m_tick;
    bit m_eval;
    bit m_valid = 1'b0;

    function automatic logic [LAMPS-1:0] mframe(int p, bit ch);
        int v;
        if (p >= LAMPS) v = 0;
        else if (ch) v = 1 << p;
        else v = (1 << (p + 1)) - 1;
        return LAMPS'(v);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0; m_side = 0; m_pos = 0; m_l = '0; m_r = '0;
        end else begin
            m_tick = (m_cnt == STEP - 1);
            m_cnt  = (m_cnt + 1) % STEP;
            if (m_tick) begin
                m_eval = 1'b0;
                case (m_side)
                    0: m_eval = 1'b1;
                    1, 2: begin
                        if (hazard) begin
                            m_side = 3; m_pos = 0; m_l = '1; m_r = '1;
                        end else if (m_pos == LAMPS) begin
                            m_eval = 1'b1;
                        end else begin
                            m_pos = m_pos + 1;
                            if (m_side == 1) m_l = mframe(m_pos, CHASE && mode);
                            else m_r = mframe(m_pos, CHASE && mode);
                        end
                    end
                    default: begin
                        if (m_l != '0) begin
                            m_l = '0; m_r = '0;
                            if (!hazard) m_side = 0;
                        end else begin
                            m_l = '1; m_r = '1;
                        end
                    end
                endcase
                if (m_eval) begin
                    m_side = 0; m_pos = 0; m_l = '0; m_r = '0;
                    if (hazard || (left_req && right_req)) begin
                        m_side = 3; m_l = '1; m_r = '1;
                    end else if (left_req) begin
                        m_side = 1; m_l = mframe(0, CHASE && mode);
                    end else if (right_req) begin
                        m_side = 2; m_r = mframe(0, CHASE && mode);
                    end
                end
            end
        end
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            n_checks++;
            if ({busy, left_lamps, right_lamps} === {(m_side != 0), m_l, m_r}) begin
                n_pass++;
            end else begin
                $display("FAIL model_cycle t=%0t got busy=%b L=%b R=%b expected busy=%b L=%b R=%b",
                         $time, busy, left_lamps, right_lamps, (m_side != 0), m_l, m_r);
            end
        end
    end

    function automatic logic [6:0] dut_st();
        return {busy, left_lamps, right_lamps};
    endfunction

    function automatic logic [6:0] mdl_st();
        return {(m_side != 0), m_l, m_r};
    endfunction

    // Literal expectation, applied to both the DUT and the model.
    task automatic chk_lit(input string name, input logic [6:0] exp);
        n_checks++;
        if (dut_st() === exp) n_pass++;
        else $display("FAIL %s dut {busy,L,R}=%b expected %b", name, dut_st(), exp);
        n_checks++;
        if (mdl_st() === exp) n_pass++;
        else $display("FAIL %s model {busy,L,R}=%b expected %b", name, mdl_st(), exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_then(input logic l, input logic r, input logic h, input logic m);
        @(negedge clk);
        rst = 1'b1; left_req = 1'b0; right_req = 1'b0; hazard = 1'b0; mode = 1'b0;
        wait_cyc(2);
        rst = 1'b0; left_req = l; right_req = r; hazard = h; mode = m;
    endtask

    initial begin
        // Reset and idle
        reset_then(1'b0, 1'b0, 1'b0, 1'b0);
        chk_lit("reset_state", 7'b0_000_000);
        wait_cyc(20);
        chk_lit("idle_20", 7'b0_000_000);

        // Left held, fill
        reset_then(1'b1, 1'b0, 1'b0, 1'b0);
        wait_cyc(3); chk_lit("left_pre_tick", 7'b0_000_000);
        wait_cyc(1); chk_lit("left_f0", 7'b1_001_000);
        wait_cyc(4); chk_lit("left_f1", 7'b1_011_000);
        wait_cyc(4); chk_lit("left_f2", 7'b1_111_000);
        wait_cyc(4); chk_lit("left_off", 7'b1_000_000);
        wait_cyc(4); chk_lit("left_repeat", 7'b1_001_000);

        // Right pulsed just before a tick, mode 1
        reset_then(1'b0, 1'b0, 1'b0, 1'b1);
        wait_cyc(3); right_req = 1'b1;
        wait_cyc(1); right_req = 1'b0;
        chk_lit("right_f0", 7'b1_000_001);
        wait_cyc(4); chk_lit("right_f1", CHASE ? 7'b1_000_010 : 7'b1_000_011);
        wait_cyc(4); chk_lit("right_f2", CHASE ? 7'b1_000_100 : 7'b1_000_111);
        wait_cyc(4); chk_lit("right_off", 7'b1_000_000);
        wait_cyc(4); chk_lit("right_idle", 7'b0_000_000);

        // Hazard preempts a left pass
        reset_then(1'b1, 1'b0, 1'b0, 1'b0);
        wait_cyc(8); chk_lit("hz_pos1", 7'b1_011_000);
        hazard = 1'b1;
        wait_cyc(3); chk_lit("hz_hold_frame", 7'b1_011_000);
        wait_cyc(1); chk_lit("hz_on1", 7'b1_111_111);
        wait_cyc(4); chk_lit("hz_off1", 7'b1_000_000);
        wait_cyc(4); chk_lit("hz_on2", 7'b1_111_111);
        hazard = 1'b0;
        wait_cyc(4); chk_lit("hz_exit", 7'b0_000_000);
        wait_cyc(4); chk_lit("hz_resume_left", 7'b1_001_000);

        // Both turn requests act as hazard
        reset_then(1'b1, 1'b1, 1'b0, 1'b0);
        wait_cyc(4); chk_lit("both_on", 7'b1_111_111);
        wait_cyc(4); chk_lit("both_off", 7'b0_000_000);
        wait_cyc(4); chk_lit("both_on2", 7'b1_111_111);

        // Reset in the middle of a right pass
        reset_then(1'b0, 1'b1, 1'b0, 1'b0);
        wait_cyc(12); chk_lit("rmid_pos2", 7'b1_000_111);
        rst = 1'b1;
        wait_cyc(1); chk_lit("rmid_blank", 7'b0_000_000);
        rst = 1'b0;
        wait_cyc(3); chk_lit("rmid_wait", 7'b0_000_000);
        wait_cyc(1); chk_lit("rmid_first", 7'b1_000_001);

        // Randomized traffic; the per-cycle model does the checking
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 5) == 0) left_req = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) right_req = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 11) == 0) hazard = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) mode = 1'($urandom_range(0, 1));
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
